// File: rtl/and_stim_seq.sv
// Stimulus sequencer and response checker for a WIDTH-input AND gate:
// walks a fixed pattern table, samples the gate output at the end of each hold window.
module and_stim_seq #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_in,
  output logic [WIDTH-1:0] x_out,
  output logic             busy,
  output logic             done,
  output logic [7:0]       err_cnt,
  output logic             pass
);

  localparam int NUM   = WIDTH + 2;
  localparam int IDX_W = $clog2(NUM);
  localparam int CNT_W = $clog2(HOLD);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Pattern table: zeros, ones, then a walking zero starting at the LSB.
  logic [WIDTH-1:0] pat_table [NUM];

  assign pat_table[0] = '0;
  assign pat_table[1] = '1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_walk
      assign pat_table[gi+2] = ~(WIDTH'(1) << gi);
    end
  endgenerate

  logic       last_sample;
  logic       last_idx;
  logic       mismatch;
  logic [7:0] err_next;

  assign last_sample = (cnt_reg == CNT_W'(HOLD - 1));
  assign last_idx    = (idx_reg == IDX_W'(NUM - 1));
  assign mismatch    = (y_in != (&x_out));
  // Saturating increment so a badly broken gate never wraps back to a clean count.
  assign err_next    = (mismatch && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      x_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_cnt   <= 8'd0;
      pass      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg <= DRIVE;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            x_out     <= pat_table[0];
            busy      <= 1'b1;
            done      <= 1'b0;
            err_cnt   <= 8'd0;
            pass      <= 1'b0;
          end
        end
        DRIVE: begin
          if (last_sample) begin
            err_cnt <= err_next;
            if (last_idx) begin
              // pass uses err_next so a final-window mismatch is already counted.
              state_reg <= DONE;
              x_out     <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (err_next == 8'd0);
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
              cnt_reg <= '0;
              x_out   <= pat_table[idx_reg + IDX_W'(1)];
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_stim_seq.sv
// Bench for and_stim_seq: an 8-wide/HOLD=4 and a 4-wide/HOLD=2 instance,
// checked cycle by cycle against a pattern/mismatch model built from the sequence rules.
module tb_and_stim_seq;

  localparam int M_REAL = 0;
  localparam int M_S0   = 1;
  localparam int M_S1   = 2;
  localparam int M_GL   = 3;
  localparam int M_RND  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_drv = 1'b0;
  logic y_drv = 1'b0;
  logic sel4 = 1'b0;
  int   ymode = M_REAL;

  logic       start8, y8, busy8, done8, pass8;
  logic [7:0] x8, err8;
  logic       start4, y4, busy4, done4, pass4;
  logic [3:0] x4;
  logic [7:0] err4;

  int n_cmp = 0;
  int n_err = 0;

  assign start8 = start_drv & ~sel4;
  assign start4 = start_drv & sel4;
  assign y8 = (ymode == M_REAL) ? (&x8) : y_drv;
  assign y4 = (ymode == M_REAL) ? (&x4) : y_drv;

  logic [7:0] x_obs, err_obs;
  logic       busy_obs, done_obs, pass_obs;
  assign x_obs    = sel4 ? {4'b0, x4} : x8;
  assign err_obs  = sel4 ? err4 : err8;
  assign busy_obs = sel4 ? busy4 : busy8;
  assign done_obs = sel4 ? done4 : done8;
  assign pass_obs = sel4 ? pass4 : pass8;

  and_stim_seq #(.WIDTH(8), .HOLD(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .y_in(y8),
    .x_out(x8), .busy(busy8), .done(done8), .err_cnt(err8), .pass(pass8)
  );

  and_stim_seq #(.WIDTH(4), .HOLD(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .y_in(y4),
    .x_out(x4), .busy(busy4), .done(done4), .err_cnt(err4), .pass(pass4)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected pattern i of a w-wide run, from plain arithmetic.
  function automatic logic [7:0] pat(input int i, input int w);
    int full;
    full = (1 << w) - 1;
    if (i == 0) return 8'd0;
    if (i == 1) return 8'(full);
    return 8'(full - (1 << (i - 2)));
  endfunction

  // Launch one run on the selected instance and follow it cycle by cycle.
  task automatic run_seq(input int mode, input bit keep, input int pulse_at, input string name);
    int w, h, total, mism, p;
    logic [7:0] exp_x, exp_err;
    logic ys;
    w = sel4 ? 4 : 8;
    h = sel4 ? 2 : 4;
    total = (w + 2) * h;
    mism = 0;
    ymode = mode;
    start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = keep;
    for (int c = 0; c < total; c++) begin
      p = c / h;
      exp_x = pat(p, w);
      case (mode)
        M_S0:    y_drv = 1'b0;
        M_S1:    y_drv = 1'b1;
        M_GL:    y_drv = (p == 1) && ((c % h) != h - 1);
        M_RND:   y_drv = 1'($urandom_range(0, 1));
        default: y_drv = 1'b0;
      endcase
      if (c == pulse_at) start_drv = 1'b1;
      else if (!keep) start_drv = 1'b0;
      exp_err = (mism > 255) ? 8'd255 : 8'(mism);
      @(negedge clk);
      n_cmp++;
      if (x_obs !== exp_x) begin
        n_err++;
        $display("FAIL %s x_out c=%0d got %h want %h", name, c, x_obs, exp_x);
      end
      n_cmp++;
      if (busy_obs !== 1'b1 || done_obs !== 1'b0 || pass_obs !== 1'b0) begin
        n_err++;
        $display("FAIL %s flags c=%0d got busy=%b done=%b pass=%b want 1/0/0", name, c, busy_obs, done_obs, pass_obs);
      end
      n_cmp++;
      if (err_obs !== exp_err) begin
        n_err++;
        $display("FAIL %s err_cnt c=%0d got %0d want %0d", name, c, err_obs, exp_err);
      end
      if ((c % h) == h - 1) begin
        ys = (mode == M_REAL) ? (p == 1) : y_drv;
        if (ys != (p == 1)) mism++;
      end
      @(posedge clk); #1;
    end
    exp_err = (mism > 255) ? 8'd255 : 8'(mism);
    @(negedge clk);
    n_cmp++;
    if (done_obs !== 1'b1 || busy_obs !== 1'b0 || x_obs !== 8'd0) begin
      n_err++;
      $display("FAIL %s end got done=%b busy=%b x=%h want 1/0/00", name, done_obs, busy_obs, x_obs);
    end
    n_cmp++;
    if (err_obs !== exp_err || pass_obs !== (exp_err == 0)) begin
      n_err++;
      $display("FAIL %s result got err=%0d pass=%b want err=%0d pass=%b", name, err_obs, pass_obs, exp_err, exp_err == 0);
    end
    $display("run %s: width=%0d err_cnt=%0d pass=%b", name, w, err_obs, pass_obs);
  endtask

  task automatic test_reset();
    #1;
    start_drv = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (x8 !== 8'd0 || busy8 !== 1'b0 || done8 !== 1'b0 || err8 !== 8'd0 || pass8 !== 1'b0) begin
      n_err++;
      $display("FAIL reset8 got x=%h busy=%b done=%b err=%h pass=%b want all zero", x8, busy8, done8, err8, pass8);
    end
    n_cmp++;
    if (x4 !== 4'd0 || busy4 !== 1'b0 || done4 !== 1'b0 || err4 !== 8'd0 || pass4 !== 1'b0) begin
      n_err++;
      $display("FAIL reset4 got x=%h busy=%b done=%b err=%h pass=%b want all zero", x4, busy4, done4, err4, pass4);
    end
    repeat (3) @(posedge clk);
    #1;
    start_drv = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || x8 !== 8'd0) begin
        n_err++;
        $display("FAIL idle_after_reset cyc=%0d got busy=%b done=%b x=%h want 0/0/00", i, busy8, done8, x8);
      end
    end
    $display("reset: checked async assertion and idle after release");
  endtask

  task automatic test_nominal();
    sel4 = 1'b0;
    run_seq(M_REAL, 1'b0, -1, "nominal");
  endtask

  task automatic test_faults();
    sel4 = 1'b0;
    run_seq(M_S0, 1'b0, -1, "stuck0");
    run_seq(M_S1, 1'b0, -1, "stuck1");
    run_seq(M_GL, 1'b0, -1, "glitch");
  endtask

  task automatic test_handshake();
    sel4 = 1'b0;
    run_seq(M_REAL, 1'b0, 10, "start_mid_run");
  endtask

  task automatic test_back_to_back();
    sel4 = 1'b0;
    run_seq(M_S1, 1'b1, -1, "b2b_first");
    run_seq(M_REAL, 1'b0, -1, "b2b_second");
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      sel4 = (r >= 3);
      run_seq(M_RND, 1'b0, -1, "random");
    end
  endtask

  task automatic test_reset_mid_run();
    sel4 = 1'b0;
    ymode = M_REAL;
    start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (x8 !== pat(3, 8)) begin
      n_err++;
      $display("FAIL mid_run_pattern got %h want %h", x8, pat(3, 8));
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (x8 !== 8'd0 || busy8 !== 1'b0 || done8 !== 1'b0 || err8 !== 8'd0 || pass8 !== 1'b0) begin
      n_err++;
      $display("FAIL mid_run_reset got x=%h busy=%b done=%b err=%h pass=%b want all zero", x8, busy8, done8, err8, pass8);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || x8 !== 8'd0) begin
        n_err++;
        $display("FAIL idle_after_abort cyc=%0d got busy=%b done=%b x=%h want 0/0/00", i, busy8, done8, x8);
      end
    end
    $display("reset_mid_run: aborted at pattern FD, idle afterwards");
  endtask

  task automatic test_sweep();
    sel4 = 1'b1;
    run_seq(M_REAL, 1'b0, -1, "sweep_w4_h2");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_faults();
    test_handshake();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/and_stim_seq.md
Name: and_stim_seq

Overview:
Sequential stimulus generator and response checker that sits directly upstream of the parameterised AND gate. It drives the gate's input vector through a fixed pattern sequence, holding each pattern for a programmable number of cycles. It samples the gate output at the end of each hold window, compares it against the expected AND-reduction and counts mismatches. It is synthesisable and usable both in benches and on-board with a switch/LED harness.

Parameters:
WIDTH, 8, width of the driven vector (matches the gate's input width); legal range ≥2.
HOLD, 200, clock cycles each pattern is held; legal range ≥2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  level; sampled in IDLE/DONE to launch a run.
y_in  input  1  output of the AND gate under test.
x_out  output  WIDTH  vector driven into the AND gate.
busy  output  1  high while the sequence runs.
done  output  1  high while in DONE.
err_cnt  output  8  mismatch count for the current/last run, saturating.
pass  output  1  high in DONE when err_cnt==0; low otherwise.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, x_out=0, busy=0, done=0, err_cnt=0, pass=0, idx=0, hold counter=0. Outputs change immediately on reset assertion, with no clock edge needed.
- Pattern table, NUM=WIDTH+2 entries:
  - idx0 = all zeros.
  - idx1 = all ones.
  - idx(2+k) = all ones with bit k cleared, for k=0..WIDTH-1 (walking zero, LSB first).
- Expected response: exp = &x_out. It is 1 only for idx1.
- FSM states: IDLE, DRIVE, DONE.
  - IDLE: x_out=0, busy=0, done=0. If start=1 at a rising edge, go to DRIVE with idx=0, cnt=0, err_cnt=0.
  - DRIVE: busy=1, x_out=pattern(idx) (registered). cnt increments each cycle.
    - At cnt==HOLD-1: compare y_in with exp. On mismatch, err_cnt+1, saturating at 255.
    - Then if idx==NUM-1, go to DONE. Otherwise idx+1 and cnt=0.
  - DONE: x_out=0, busy=0, done=1, pass=(err_cnt==0), err_cnt held. If start=1 at an edge, go to DRIVE exactly as from IDLE; err_cnt is cleared on that edge.
- Timing:
  - x_out presents pattern 0 in the cycle after the edge that sampled start.
  - Each pattern is visible for exactly HOLD cycles.
  - busy is high for exactly NUM*HOLD cycles.
  - done rises on the edge after the final sample.
- y_in is sampled only on the last cycle of each hold window. This gives the DUT HOLD-1 cycles to settle; y_in is ignored at all other times.
- start is ignored while in DRIVE. A start held high continuously in DONE causes back-to-back runs with one DONE cycle between them.
- Simultaneous events:
  - A final-pattern mismatch and the DRIVE→DONE transition on the same edge: the count includes that mismatch before pass is evaluated.
  - Saturation at 255 holds; err_cnt never wraps.
- Reset mid-run: abort immediately to the reset values. No partial result is retained. After release, the block waits in IDLE for start.
- Counter widths: idx needs ceil(log2(NUM)) bits; cnt needs ceil(log2(HOLD)) bits.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle with start=1 → x_out=0, busy=0, done=0, err_cnt=0, pass=0 without waiting for a clock edge. Stay in IDLE after release only if start=0.
2. Nominal run (WIDTH=8, HOLD=4, real 8-input AND as DUT): 1-cycle start pulse → x_out = 00,FF,FE,FD,FB,F7,EF,DF,BF,7F, each for 4 cycles. busy high for 40 cycles. Then done=1, err_cnt=0, pass=1.
3. Faulty DUT:
   - y_in stuck 0 → err_cnt=1 (FF window only), pass=0.
   - y_in stuck 1 → err_cnt=9, pass=0.
   - y_in=1 for the first 3 cycles of the FF window and 0 on its last cycle → err_cnt=1.
4. Handshake: pulse start again at run cycle 10 → sequence unaffected, done still after 40 cycles. Assert start in DONE → new run begins, err_cnt cleared to 0 on the launch edge, x_out=00 the next cycle.
5. Reset mid-run at run cycle 13 (pattern FD) → x_out=0, busy=0 immediately. After release with start=0, remains in IDLE indefinitely.
6. Parameter sweep (WIDTH=4, HOLD=2, real 4-input AND): start → x_out = 0,F,E,D,B,7 at 2 cycles each, busy for 12 cycles, pass=1.
